instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the 4-bit computer. It consumes the program counter's address and its `cp` clock-pulse strobe, and reads the addressed word from an internal 16-entry program memory. It then presents the word to the decode/execute stage as opcode and operand nibbles under a valid/ready handshake. A separate write port lets the loader or testbench fill program memory before or during a run.

## Interface
Parameters:
- `DATA_W`, 8: instruction width. Must be even. Opcode is the upper `DATA_W/2` bits; operand is the lower `DATA_W/2` bits.
- `ADDR_W`, 4: program address width. Memory depth is `2**ADDR_W`.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `cp`  in  1: clock-pulse level from the program counter, synchronous to `clk`.
- `programCount`  in  ADDR_W: current program address from the program counter.
- `prog_we`  in  1: program memory write enable.
- `prog_waddr`  in  ADDR_W: write address.
- `prog_wdata`  in  DATA_W: write data.
- `instr_ready`  in  1: consumer accepts the instruction.
- `instr_valid`  out  1: instruction outputs are valid.
- `opcode`  out  DATA_W/2: fetched opcode.
- `operand`  out  DATA_W/2: fetched operand.
- `instr_addr`  out  ADDR_W: address the presented instruction was fetched from.
- `overrun`  out  1: sticky flag. Set when a `cp` rising edge arrives and cannot start a fetch.

## Operation
- Edge detect: `cp_d` holds the previous sample of `cp`. A fetch request occurs when `cp`=1 and `cp_d`=0. `cp_d` resets to 1, so `cp` held high through reset release does not trigger a fetch.
- FSM states are IDLE, FETCH and VALID.
  - IDLE: on a fetch request, capture `programCount` into the address register and go to FETCH.
  - FETCH: one-cycle synchronous memory read. The read word goes to the output registers, `instr_addr` takes the captured address, and the FSM goes to VALID.
  - VALID: `instr_valid`=1 and outputs are held stable.
    - If `instr_ready`=1 with no fetch request, go to IDLE.
    - If `instr_ready`=1 and a fetch request arrive on the same edge, capture `programCount` and go straight to FETCH. This is not an overrun.
- Overrun: a fetch request in FETCH, or in VALID without `instr_ready`, is dropped and sets `overrun`. Only `rst` clears `overrun`.
- Memory:
  - Writes occur at the clock edge when `prog_we`=1 and are allowed in any state.
  - If a write and a FETCH read hit the same address on the same edge, the read returns the old data (read-before-write).
  - Memory contents are not cleared by reset. Power-up contents are undefined.
- Reset values: `instr_valid`=0, `opcode`=0, `operand`=0, `instr_addr`=0, `overrun`=0, state IDLE.
- Reset mid-operation: any in-flight fetch is abandoned immediately and outputs return to reset values asynchronously. Memory contents are retained.

## Timing
- Edge numbering: edge n is the first `clk` edge that samples `cp`=1 with `cp_d`=0.
  - Edge n: address captured.
  - Edge n+1: memory read, outputs loaded, `instr_valid` rises.
  - `instr_valid` is visible during cycle n+1 to n+2. Latency is 2 edges from request to valid.
- Handshake: a transfer happens on an edge with `instr_valid`=1 and `instr_ready`=1.
  - `instr_valid` falls at that edge unless a simultaneous request restarts the FSM in FETCH. In that case `instr_valid` is low for one cycle, then high again.
  - Outputs do not change while `instr_valid`=1 and `instr_ready`=0.
- Peak throughput is one instruction per 2 clocks. The program counter's `cp` period (≥4 clocks) never overruns when the consumer holds `instr_ready`=1.
- `programCount` wraps from 15 to 0 upstream. The fetch unit treats address 0 after 15 as an ordinary fetch.
- `cp` high for several clocks produces exactly one request. A new request needs `cp` to go low, then high again.

## Test plan
- Load mem[0..15] = 8'h10+i. Hold `instr_ready`=1 and pulse `cp` with `programCount`=5. Expect `instr_valid` at edge n+1 with `opcode`=4'h1, `operand`=4'h5, `instr_addr`=5, and `overrun`=0.
- Hold `instr_ready`=0 after a fetch of address 3 and issue a second `cp` edge with `programCount`=4. Expect outputs to stay at address 3 and `overrun`=1. After `instr_ready` pulses, `overrun` stays 1.
- In VALID, assert `instr_ready` and a `cp` rising edge on the same edge with `programCount`=7. Expect `instr_valid` low for one cycle, then mem[7] presented, and `overrun`=0.
- Write mem[9]=8'hA5 on the same edge as the FETCH read of address 9 (old value 8'h19). Expect 8'h19 presented. A refetch of address 9 returns `opcode`=4'hA, `operand`=4'h5.
- Sweep `programCount` 14, 15, 0 with a free-running `cp` (period 4) and `instr_ready`=1. Expect three consecutive instructions with `instr_addr` 14, 15, 0 and no overrun.
- Assert `rst` during FETCH with `cp` held high. Expect all outputs 0 immediately and no fetch after release until `cp` goes low then high. Memory contents must be intact.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit for the 4-bit computer. A rising edge on the program
// counter's cp level starts a fetch of programCount from a 2**ADDR_W deep
// program memory. The word is presented to decode/execute as opcode (upper
// half) and operand (lower half) under a valid/ready handshake.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   cp            in   clock-pulse level from the program counter (clk domain)
//   programCount  in   [ADDR_W]  address to fetch
//   prog_we       in   program memory write enable
//   prog_waddr    in   [ADDR_W]  program memory write address
//   prog_wdata    in   [DATA_W]  program memory write data
//   instr_ready   in   consumer accepts the presented instruction
//   instr_valid   out  opcode/operand/instr_addr are valid
//   opcode        out  [DATA_W/2] upper half of the fetched word
//   operand       out  [DATA_W/2] lower half of the fetched word
//   instr_addr    out  [ADDR_W]  address the presented word came from
//   overrun       out  sticky: a cp request arrived that could not be served
//
// DATA_W must be even.
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cp,
   input  logic [ADDR_W-1:0]     programCount,
   input  logic                  prog_we,
   input  logic [ADDR_W-1:0]     prog_waddr,
   input  logic [DATA_W-1:0]     prog_wdata,
   input  logic                  instr_ready,
   output logic                  instr_valid,
   output logic [DATA_W/2-1:0]   opcode,
   output logic [DATA_W/2-1:0]   operand,
   output logic [ADDR_W-1:0]     instr_addr,
   output logic                  overrun
);

   localparam int HALF_W = DATA_W / 2;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                cp_q;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
   logic [HALF_W-1:0]   opcode_q, opcode_d;
   logic [HALF_W-1:0]   operand_q, operand_d;
   logic                overrun_q, overrun_d;
   logic                fetch_req;

   // Program memory. Not reset: contents survive rst.
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   rd_word;

   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_q[prog_waddr] <= prog_wdata;
      end
   end

   // The read is only consumed into registers on the FETCH edge, so a write
   // to the same address on that edge is not yet visible (read-before-write).
   assign rd_word = mem_q[addr_q];

   // cp_q resets to 1 so a cp level held high across reset release is not
   // mistaken for a new rising edge.
   assign fetch_req = cp & ~cp_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      instr_addr_d = instr_addr_q;
      opcode_d     = opcode_q;
      operand_d    = operand_q;
      overrun_d    = overrun_q;

      unique case (state_q)
         IDLE: begin
            if (fetch_req) begin
               addr_d  = programCount;
               state_d = FETCH;
            end
         end

         FETCH: begin
            opcode_d     = rd_word[DATA_W-1:HALF_W];
            operand_d    = rd_word[HALF_W-1:0];
            instr_addr_d = addr_q;
            state_d      = VALID;
            if (fetch_req) begin
               overrun_d = 1'b1;
            end
         end

         VALID: begin
            if (instr_ready) begin
               // A request coinciding with the transfer restarts the fetch
               // directly; the address register is free at this point.
               if (fetch_req) begin
                  addr_d  = programCount;
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end else if (fetch_req) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cp_q         <= 1'b1;
         addr_q       <= '0;
         instr_addr_q <= '0;
         opcode_q     <= '0;
         operand_q    <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cp_q         <= cp;
         addr_q       <= addr_d;
         instr_addr_q <= instr_addr_d;
         opcode_q     <= opcode_d;
         operand_q    <= operand_d;
         overrun_q    <= overrun_d;
      end
   end

   assign instr_valid = (state_q == VALID);
   assign opcode      = opcode_q;
   assign operand     = operand_q;
   assign instr_addr  = instr_addr_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed testbench for instr_fetch. Inputs are driven and outputs sampled
// on the falling clock edge. Outputs are compared as one packed vector
// {instr_valid, opcode, operand, instr_addr, overrun}.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic       clk;
   logic       rst;
   logic       cp;
   logic [3:0] programCount;
   logic       prog_we;
   logic [3:0] prog_waddr;
   logic [7:0] prog_wdata;
   logic       instr_ready;
   logic       instr_valid;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [3:0] instr_addr;
   logic       overrun;

   int n_cmp;
   int n_err;

   logic [13:0] obs;
   logic [13:0] exp_v;

   instr_fetch #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cp           (cp),
      .programCount (programCount),
      .prog_we      (prog_we),
      .prog_waddr   (prog_waddr),
      .prog_wdata   (prog_wdata),
      .instr_ready  (instr_ready),
      .instr_valid  (instr_valid),
      .opcode       (opcode),
      .operand      (operand),
      .instr_addr   (instr_addr),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] outs();
      return {instr_valid, opcode, operand, instr_addr, overrun};
   endfunction

   task automatic nclk(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      nclk(2);
      rst = 1'b0;
      nclk(1);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      cp = 1'b0; programCount = '0; prog_we = 1'b0; prog_waddr = '0;
      prog_wdata = '0; instr_ready = 1'b0;
      nclk(2);
      obs = outs(); exp_v = 14'h0; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_state: got %h want %h", obs, exp_v);
      end
      rst = 1'b0;
      nclk(2);
      obs = outs(); n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_release_idle: got %h want %h", obs, exp_v);
      end
      $display("test_reset done");
   endtask

   task automatic load_memory();
      for (int i = 0; i < 16; i++) begin
         prog_we = 1'b1; prog_waddr = 4'(i); prog_wdata = 8'(8'h10 + i);
         nclk(1);
      end
      prog_we = 1'b0;
      $display("memory loaded with 8'h10+i");
   endtask

   // ---------------------------------------------------------------------
   task automatic test_basic_fetch();
      instr_ready = 1'b1; programCount = 4'd5; cp = 1'b1;
      nclk(1);                       // edge n: address captured
      obs = outs(); n_cmp++;
      if (obs[13] !== 1'b0) begin
         n_err++;
         $display("FAIL basic_not_yet_valid: got valid=%b want 0", obs[13]);
      end
      cp = 1'b0;
      nclk(1);                       // edge n+1: valid
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h5, 4'd5, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL basic_fetch_addr5: got %h want %h", obs, exp_v);
      end
      nclk(1);                       // transfer accepted
      obs = outs(); n_cmp++;
      if (obs[13] !== 1'b0) begin
         n_err++;
         $display("FAIL basic_valid_drop: got valid=%b want 0", obs[13]);
      end
      $display("test_basic_fetch addr=5 opcode=%h operand=%h", opcode, operand);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_overrun();
      apply_reset();
      instr_ready = 1'b0; programCount = 4'd3; cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h3, 4'd3, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL overrun_first_fetch: got %h want %h", obs, exp_v);
      end
      programCount = 4'd4; cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h3, 4'd3, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL overrun_hold_and_flag: got %h want %h", obs, exp_v);
      end
      instr_ready = 1'b1;
      nclk(1);
      instr_ready = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b0, 4'h1, 4'h3, 4'd3, 1'b1}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL overrun_sticky: got %h want %h", obs, exp_v);
      end
      $display("test_overrun overrun=%b", overrun);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_back_to_back();
      apply_reset();
      instr_ready = 1'b0; programCount = 4'd2; cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h2, 4'd2, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL b2b_first: got %h want %h", obs, exp_v);
      end
      instr_ready = 1'b1; programCount = 4'd7; cp = 1'b1;
      nclk(1);                       // transfer + request on the same edge
      cp = 1'b0;
      obs = outs(); n_cmp++;
      if (obs[13] !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_valid_gap: got valid=%b want 0", obs[13]);
      end
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h7, 4'd7, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL b2b_second: got %h want %h", obs, exp_v);
      end
      nclk(1);
      $display("test_back_to_back addr=7 overrun=%b", overrun);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_read_before_write();
      instr_ready = 1'b0; programCount = 4'd9; cp = 1'b1;
      nclk(1);                       // in FETCH now
      cp = 1'b0;
      prog_we = 1'b1; prog_waddr = 4'd9; prog_wdata = 8'hA5;
      nclk(1);                       // read and write of address 9 together
      prog_we = 1'b0;
      obs = outs(); exp_v = {1'b1, 4'h1, 4'h9, 4'd9, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rbw_old_data: got %h want %h", obs, exp_v);
      end
      instr_ready = 1'b1;
      nclk(1);
      cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'hA, 4'h5, 4'd9, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rbw_new_data: got %h want %h", obs, exp_v);
      end
      nclk(1);
      $display("test_read_before_write refetch opcode=%h operand=%h", opcode, operand);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_wrap();
      logic [3:0] pcs [3];
      pcs[0] = 4'd14; pcs[1] = 4'd15; pcs[2] = 4'd0;
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         programCount = pcs[k]; cp = 1'b1;
         nclk(2);                    // cp high for two clocks, one request
         cp = 1'b0;
         obs = outs(); exp_v = {1'b1, 4'h1, pcs[k], pcs[k], 1'b0}; n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wrap_addr%0d: got %h want %h", pcs[k], obs, exp_v);
         end
         nclk(2);
         $display("test_wrap fetched addr=%0d", instr_addr);
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_mid_fetch();
      instr_ready = 1'b1; programCount = 4'd11; cp = 1'b1;
      nclk(1);                       // in FETCH, cp still high
      rst = 1'b1;
      #1;
      obs = outs(); exp_v = 14'h0; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rst_async_clear: got %h want %h", obs, exp_v);
      end
      nclk(2);
      rst = 1'b0;
      nclk(3);                       // cp held high through release
      obs = outs(); n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rst_no_spurious_fetch: got %h want %h", obs, exp_v);
      end
      cp = 1'b0;
      nclk(1);
      cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'h1, 4'hB, 4'd11, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rst_mem_kept_11: got %h want %h", obs, exp_v);
      end
      nclk(1);
      programCount = 4'd9; cp = 1'b1;
      nclk(1);
      cp = 1'b0;
      nclk(1);
      obs = outs(); exp_v = {1'b1, 4'hA, 4'h5, 4'd9, 1'b0}; n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL rst_mem_kept_9: got %h want %h", obs, exp_v);
      end
      nclk(1);
      $display("test_reset_mid_fetch done");
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      load_memory();
      test_basic_fetch();
      test_overrun();
      test_back_to_back();
      test_read_before_write();
      test_wrap();
      test_reset_mid_fetch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
